// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: default widths and
// the architectural indices that get special treatment (x0 hardwired, x1 fetch port).
package regfile_sb_pkg;

  localparam int XLEN          = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int REG_X0        = 0;
  localparam int REG_X1        = 1;

endpackage

// File: rtl/regfile_sb_bypass.sv
// Priority match of one read index against all write-back ports.
// The highest-numbered matching port wins, mirroring write ordering into the array.
module regfile_sb_bypass #(
  parameter int XLEN  = 32,
  parameter int NWR   = 2,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*IDX_W-1:0]  wr_idx,
  input  logic [NWR*XLEN-1:0]   wr_data,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan so a later (higher) port overrides an earlier match.
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && (wr_idx[k*IDX_W +: IDX_W] == idx)) begin
        hit  = 1'b1;
        data = wr_data[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with same-cycle bypass, a dedicated x1 fetch port
// and a per-register busy scoreboard (set on issue, cleared on write-back/flush).
module regfile_sb #(
  parameter int XLEN    = regfile_sb_pkg::XLEN,
  parameter int REG_NUM = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int IDX_W   = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*IDX_W-1:0] wr_idx_i,
  input  logic [NWR*XLEN-1:0]  wr_data_i,
  input  logic [NRD-1:0]       rd_en_i,
  input  logic [NRD*IDX_W-1:0] rd_idx_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic                 iss_valid_i,
  input  logic [IDX_W-1:0]     iss_idx_i,
  output logic                 iss_ready_o,
  input  logic                 flush_i,
  output logic [XLEN-1:0]      x1_data_o,
  output logic                 x1_busy_o
);

  import regfile_sb_pkg::*;

  localparam logic [IDX_W-1:0] IDX_X0 = IDX_W'(REG_X0);
  localparam logic [IDX_W-1:0] IDX_X1 = IDX_W'(REG_X1);

  logic [XLEN-1:0]    regs [REG_NUM];
  logic [REG_NUM-1:0] busy_reg;
  logic [REG_NUM-1:0] busy_next;
  logic               iss_set;

  // Ready looks only at registered busy so a write-back in flight cannot
  // let a second writer to the same register slip through (WAW guard).
  assign iss_ready_o = ~busy_reg[iss_idx_i];
  assign iss_set     = iss_valid_i && iss_ready_o && (iss_idx_i != IDX_X0);

  always_comb begin
    busy_next = busy_reg;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en_i[k] && (wr_idx_i[k*IDX_W +: IDX_W] != IDX_X0))
        busy_next[wr_idx_i[k*IDX_W +: IDX_W]] = 1'b0;
    end
    // Order encodes priority: issue set beats write-back clear, flush beats both.
    if (iss_set)
      busy_next[iss_idx_i] = 1'b1;
    if (flush_i)
      busy_next = '0;
    busy_next[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++)
        regs[r] <= '0;
      busy_reg <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && (wr_idx_i[k*IDX_W +: IDX_W] != IDX_X0))
          regs[wr_idx_i[k*IDX_W +: IDX_W]] <= wr_data_i[k*XLEN +: XLEN];
      end
      busy_reg <= busy_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [IDX_W-1:0] idx;
      logic             hit;
      logic [XLEN-1:0]  byp_data;
      logic [XLEN-1:0]  data;
      logic             busy;

      assign idx = rd_idx_i[gi*IDX_W +: IDX_W];

      regfile_sb_bypass #(
        .XLEN  (XLEN),
        .NWR   (NWR),
        .IDX_W (IDX_W)
      ) u_bypass (
        .idx     (idx),
        .wr_en   (wr_en_i),
        .wr_idx  (wr_idx_i),
        .wr_data (wr_data_i),
        .hit     (hit),
        .data    (byp_data)
      );

      always_comb begin
        data = '0;
        busy = 1'b0;
        if (rd_en_i[gi] && (idx != IDX_X0)) begin
          if (hit) begin
            data = byp_data;
          end else begin
            data = regs[idx];
            busy = busy_reg[idx];
          end
        end
      end

      assign rd_data_o[gi*XLEN +: XLEN] = data;
      assign rd_busy_o[gi]              = busy;
    end
  endgenerate

  logic            x1_hit;
  logic [XLEN-1:0] x1_byp_data;

  regfile_sb_bypass #(
    .XLEN  (XLEN),
    .NWR   (NWR),
    .IDX_W (IDX_W)
  ) u_bypass_x1 (
    .idx     (IDX_X1),
    .wr_en   (wr_en_i),
    .wr_idx  (wr_idx_i),
    .wr_data (wr_data_i),
    .hit     (x1_hit),
    .data    (x1_byp_data)
  );

  assign x1_data_o = x1_hit ? x1_byp_data : regs[REG_X1];
  assign x1_busy_o = x1_hit ? 1'b0 : busy_reg[REG_X1];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: each scenario queues expected output values
// while driving inputs, then drains the queue against sampled DUT outputs.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int IDX_W = 5;

  localparam int S_RD0_DATA = 0;
  localparam int S_RD0_BUSY = 1;
  localparam int S_RD1_DATA = 2;
  localparam int S_RD1_BUSY = 3;
  localparam int S_X1_DATA  = 4;
  localparam int S_X1_BUSY  = 5;
  localparam int S_ISS_RDY  = 6;

  logic                 clk;
  logic                 rst_n;
  logic [NWR-1:0]       wr_en;
  logic [NWR*IDX_W-1:0] wr_idx;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NRD-1:0]       rd_en;
  logic [NRD*IDX_W-1:0] rd_idx;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_valid;
  logic [IDX_W-1:0]     iss_idx;
  logic                 iss_ready;
  logic                 flush;
  logic [XLEN-1:0]      x1_data;
  logic                 x1_busy;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [31:0] model [32];

  regfile_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_data_i   (wr_data),
    .rd_en_i     (rd_en),
    .rd_idx_i    (rd_idx),
    .rd_data_o   (rd_data),
    .rd_busy_o   (rd_busy),
    .iss_valid_i (iss_valid),
    .iss_idx_i   (iss_idx),
    .iss_ready_o (iss_ready),
    .flush_i     (flush),
    .x1_data_o   (x1_data),
    .x1_busy_o   (x1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_RD0_DATA: return rd_data[31:0];
      S_RD0_BUSY: return {31'b0, rd_busy[0]};
      S_RD1_DATA: return rd_data[63:32];
      S_RD1_BUSY: return {31'b0, rd_busy[1]};
      S_X1_DATA:  return x1_data;
      S_X1_BUSY:  return {31'b0, x1_busy};
      default:    return {31'b0, iss_ready};
    endcase
  endfunction

  task automatic push(string name, int sel, logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    wr_en     = '0;
    wr_idx    = '0;
    wr_data   = '0;
    rd_en     = '0;
    rd_idx    = '0;
    iss_valid = 1'b0;
    iss_idx   = '0;
    flush     = 1'b0;
  endtask

  task automatic set_wr(int p, int idx, logic [31:0] d);
    wr_en[p]                 = 1'b1;
    wr_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    wr_data[p*XLEN +: XLEN]  = d;
  endtask

  task automatic set_rd(int p, int idx);
    rd_en[p]                 = 1'b1;
    rd_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  // Advance one clock: inputs change on the falling edge, outputs are sampled 2ns later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_rd(0, 5);
    set_rd(1, 0);
    iss_idx = 5'd5;
    #2;
    push("reset_rd0_data_x5", S_RD0_DATA, 32'h0);
    push("reset_rd0_busy_x5", S_RD0_BUSY, 32'h0);
    push("reset_rd1_data_x0", S_RD1_DATA, 32'h0);
    push("reset_rd1_busy_x0", S_RD1_BUSY, 32'h0);
    push("reset_x1_data",     S_X1_DATA,  32'h0);
    push("reset_x1_busy",     S_X1_BUSY,  32'h0);
    push("reset_iss_ready",   S_ISS_RDY,  32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] obs;
    set_wr(0, 3, 32'hDEADBEEF);
    set_rd(0, 3);
    rd_idx[IDX_W +: IDX_W] = 5'd3;  // port 1 points at x3 but stays disabled
    #2;
    push("bypass_rd0_data_x3", S_RD0_DATA, 32'hDEADBEEF);
    push("bypass_rd0_busy_x3", S_RD0_BUSY, 32'h0);
    push("disabled_rd1_data",  S_RD1_DATA, 32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
    set_rd(0, 3);
    #2;
    push("array_rd0_data_x3", S_RD0_DATA, 32'hDEADBEEF);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
  endtask

  task automatic test_same_idx();
    exp_t e;
    logic [31:0] obs;
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    set_rd(1, 7);
    #2;
    push("dual_wr_bypass_x7", S_RD1_DATA, 32'h22);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
    set_rd(1, 7);
    #2;
    push("dual_wr_array_x7", S_RD1_DATA, 32'h22);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
  endtask

  task automatic test_issue_waw();
    exp_t e;
    logic [31:0] obs;
    iss_valid = 1'b1;
    iss_idx   = 5'd4;
    set_rd(0, 4);
    #2;
    push("iss_x4_ready_free", S_ISS_RDY,  32'h1);
    push("iss_x4_busy_pre",   S_RD0_BUSY, 32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
    set_rd(0, 4);
    iss_idx = 5'd4;
    #2;
    push("iss_x4_busy_set", S_RD0_BUSY, 32'h1);
    push("iss_x4_not_ready", S_ISS_RDY, 32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    // Re-issue while the write-back lands: refused, write clears busy.
    iss_valid = 1'b1;
    set_wr(0, 4, 32'h55);
    #2;
    push("waw_ready_ignores_wb", S_ISS_RDY,  32'h0);
    push("waw_bypass_data",      S_RD0_DATA, 32'h55);
    push("waw_bypass_busy",      S_RD0_BUSY, 32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
    set_rd(0, 4);
    iss_idx = 5'd4;
    #2;
    push("waw_after_data",  S_RD0_DATA, 32'h55);
    push("waw_after_busy",  S_RD0_BUSY, 32'h0);
    push("waw_after_ready", S_ISS_RDY,  32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
  endtask

  task automatic test_flush();
    exp_t e;
    logic [31:0] obs;
    iss_valid = 1'b1;
    iss_idx   = 5'd9;
    flush     = 1'b1;
    step();
    set_rd(0, 9);
    iss_idx = 5'd9;
    #2;
    push("flush_beats_issue_busy", S_RD0_BUSY, 32'h0);
    push("flush_beats_issue_rdy",  S_ISS_RDY,  32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    iss_valid = 1'b1;
    set_wr(1, 9, 32'h99);
    step();
    set_rd(0, 9);
    iss_idx = 5'd9;
    #2;
    push("issue_beats_wb_busy", S_RD0_BUSY, 32'h1);
    push("issue_beats_wb_data", S_RD0_DATA, 32'h99);
    push("issue_beats_wb_rdy",  S_ISS_RDY,  32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    flush = 1'b1;
    set_wr(0, 9, 32'hAA);
    step();
    set_rd(0, 9);
    iss_idx = 5'd9;
    #2;
    push("flush_wr_data", S_RD0_DATA, 32'hAA);
    push("flush_wr_busy", S_RD0_BUSY, 32'h0);
    push("flush_wr_rdy",  S_ISS_RDY,  32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
  endtask

  task automatic test_x1_x0();
    exp_t e;
    logic [31:0] obs;
    set_wr(1, 1, 32'h80001000);
    #2;
    push("x1_bypass_data", S_X1_DATA, 32'h80001000);
    push("x1_bypass_busy", S_X1_BUSY, 32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
    iss_valid = 1'b1;
    iss_idx   = 5'd1;
    step();
    set_wr(0, 0, 32'hFF);
    set_rd(0, 0);
    iss_valid = 1'b1;
    iss_idx   = 5'd0;
    #2;
    push("x1_busy_after_issue", S_X1_BUSY,  32'h1);
    push("x1_data_held",        S_X1_DATA,  32'h80001000);
    push("x0_wr_bypass_data",   S_RD0_DATA, 32'h0);
    push("x0_iss_ready",        S_ISS_RDY,  32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
    set_rd(0, 0);
    iss_idx = 5'd0;
    #2;
    push("x0_array_data",  S_RD0_DATA, 32'h0);
    push("x0_array_busy",  S_RD0_BUSY, 32'h0);
    push("x0_ready_after", S_ISS_RDY,  32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
  endtask

  // Random traffic on x16..x31 (with occasional x0) against a reference array.
  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] obs;
    int          widx [NWR];
    logic [31:0] wdat [NWR];
    logic        wen  [NWR];
    int          ridx;
    logic [31:0] exp_d;
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      for (int p = 0; p < NWR; p++) begin
        wen[p]  = ($urandom_range(0, 3) != 0);
        widx[p] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(16, 31));
        wdat[p] = $urandom;
        if (wen[p]) set_wr(p, widx[p], wdat[p]);
      end
      for (int p = 0; p < NRD; p++) begin
        ridx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(16, 31));
        if (p == 1 && cyc % 3 == 0) ridx = widx[1];
        rd_idx[p*IDX_W +: IDX_W] = IDX_W'(ridx);
        rd_en[p] = ($urandom_range(0, 4) != 0);
        exp_d = 32'h0;
        if (rd_en[p] && ridx != 0) begin
          exp_d = model[ridx];
          for (int k = 0; k < NWR; k++)
            if (wen[k] && widx[k] == ridx) exp_d = wdat[k];
        end
        push($sformatf("b2b_c%0d_rd%0d_x%0d", cyc, p, ridx), (p == 0) ? S_RD0_DATA : S_RD1_DATA, exp_d);
      end
      #2;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        checks++;
        if (obs !== e.val) begin
          errors++;
          $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
        end else $display("ok   %s = %h", e.name, obs);
      end
      for (int k = 0; k < NWR; k++)
        if (wen[k] && widx[k] != 0) model[widx[k]] = wdat[k];
      step();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [31:0] obs;
    set_wr(0, 20, 32'h1234);
    set_rd(0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst_rd0_x3",  S_RD0_DATA, 32'h0);
    push("async_rst_x1_data", S_X1_DATA,  32'h0);
    push("async_rst_x1_busy", S_X1_BUSY,  32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
    rst_n = 1'b1;
    set_rd(1, 20);
    #2;
    push("async_rst_lost_wr", S_RD1_DATA, 32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      if (obs !== e.val) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, obs, e.val);
      end else $display("ok   %s = %h", e.name, obs);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_bypass();
    test_same_idx();
    test_issue_waw();
    test_flush();
    test_x1_x0();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
